// File: rtl/mac_accumulator.sv
// ============================================================================
// mac_accumulator : bias-initialised saturating MAC with round/ReLU/clamp
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accumulator #(
   parameter int PROD_W = 16,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ACC_W-1:0]  bias_i,
   input  logic              prod_valid_i,
   input  logic [PROD_W-1:0] prod_i,
   input  logic              last_i,
   output logic              prod_ready_o,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [OUT_W-1:0]  out_o,
   output logic              busy_o,
   output logic              ovf_o,
   output logic [15:0]       cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_ROUND = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   c_rnd     = {{ACC_W{1'b0}}, 1'b1} << (SHIFT-1);
   localparam logic signed [ACC_W:0]   c_out_max = {{(ACC_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [15:0]              cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic [OUT_W-1:0]         out_q, out_d;

   logic signed [ACC_W:0]    w_prod_ext;
   logic signed [ACC_W:0]    w_sum;
   logic                     w_sum_ovf;
   logic signed [ACC_W-1:0]  w_sum_sat;
   logic signed [ACC_W:0]    w_rnd_sum;
   logic signed [ACC_W:0]    w_r;
   logic [OUT_W-1:0]         w_requant;

   // One guard bit: the two top bits disagree exactly when the sum left the ACC_W range.
   assign w_prod_ext = {{(ACC_W+1-PROD_W){prod_i[PROD_W-1]}}, prod_i};
   assign w_sum      = {acc_q[ACC_W-1], acc_q} + w_prod_ext;
   assign w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
   assign w_sum_sat  = !w_sum_ovf ? w_sum[ACC_W-1:0]
                     : (w_sum[ACC_W] ? c_acc_min : c_acc_max);

   assign w_rnd_sum  = {acc_q[ACC_W-1], acc_q} + c_rnd;
   assign w_r        = w_rnd_sum >>> SHIFT;

   always_comb begin
      w_requant = w_r[OUT_W-1:0];
      if (w_r[ACC_W]) begin
         w_requant = '0;
      end else if (w_r > c_out_max) begin
         w_requant = {OUT_W{1'b1}};
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      out_d   = out_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               acc_d   = bias_i;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (prod_valid_i) begin
               acc_d = w_sum_sat;
               cnt_d = cnt_q + 16'd1;
               if (w_sum_ovf) begin
                  ovf_d = 1'b1;
               end
               if (last_i) begin
                  state_d = S_ROUND;
               end
            end
         end
         S_ROUND: begin
            out_d   = w_requant;
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         out_q   <= out_d;
      end
   end

   assign prod_ready_o = (state_q == S_ACCUM);
   assign out_valid_o  = (state_q == S_OUT);
   assign busy_o       = (state_q != S_IDLE);
   assign ovf_o        = ovf_q;
   assign cnt_o        = cnt_q;
   assign out_o        = out_q;

endmodule

`default_nettype wire

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulate-and-requantize stage that sits directly downstream of the carry-save array multiplier built from `mult_core` cells. It accepts one signed product per cycle over a valid/ready handshake and adds it to a bias-initialised accumulator. When the last term of a dot product arrives, it rounds, shifts, applies ReLU and clamps the result into an unsigned activation, then holds that activation under a second valid/ready handshake for the next layer of the classifier datapath.

## Interface
Parameters:
- PROD_W, 16, width of the signed product from the multiplier array.
- ACC_W, 32, width of the signed accumulator (ACC_W > PROD_W).
- OUT_W, 8, width of the unsigned output activation.
- SHIFT, 8, arithmetic right shift applied at requantize (1 ≤ SHIFT < ACC_W).

Ports:
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  begin a new dot product; sampled only in IDLE.
- bias_i  input  ACC_W  signed bias, loaded into the accumulator on an accepted start.
- prod_valid_i  input  1  prod_i and last_i are valid.
- prod_i  input  PROD_W  signed product from the multiplier array.
- last_i  input  1  the current product is the final term.
- prod_ready_o  output  1  stage can accept a product.
- out_valid_o  output  1  out_o holds a valid activation.
- out_ready_i  input  1  downstream accepts out_o.
- out_o  output  OUT_W  unsigned activation.
- busy_o  output  1  high in every state other than IDLE.
- ovf_o  output  1  sticky flag: the accumulator saturated during the current dot product.
- cnt_o  output  16  count of products accepted in the current dot product; wraps at 2^16.

## Operation
- States: IDLE, ACCUM, ROUND, OUT.
- **IDLE**
  - On start_i=1: acc←bias_i, cnt_o←0, ovf_o←0, go to ACCUM.
  - Otherwise stay in IDLE.
- **ACCUM**
  - prod_ready_o=1.
  - A product is accepted on a cycle with prod_valid_i & prod_ready_o.
  - On accept: acc←sat(acc + sext(prod_i)) and cnt_o←cnt_o+1.
  - If last_i=1 on the accepted product, go to ROUND.
- **Saturation**
  - The sum is computed at ACC_W+1 bits.
  - If it exceeds 2^(ACC_W-1)-1 or falls below -2^(ACC_W-1), it is clamped to that bound and ovf_o←1.
  - ovf_o stays set until the next accepted start or reset.
- **ROUND**
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits; no wrap.
  - out_o←0 if r<0; out_o←2^OUT_W-1 if r>2^OUT_W-1; otherwise out_o←r.
  - Go to OUT.
- **OUT**
  - out_valid_o=1; out_o is stable.
  - On out_ready_i=1: go to IDLE, out_valid_o←0.
- out_o keeps its last value after the handshake until the next ROUND.
- start_i is ignored in every state except IDLE.
- prod_valid_i is ignored in IDLE, ROUND and OUT.
- prod_ready_o is 0 in every state except ACCUM.

## Timing
- Reset values: state=IDLE, acc=0, prod_ready_o=0, out_valid_o=0, out_o=0, busy_o=0, ovf_o=0, cnt_o=0. Reset overrides every other input.
- Reset mid-operation: returns to IDLE at the next edge; any partial sum and pending output are discarded.
- Start latency: start_i accepted at edge E → prod_ready_o=1 from edge E+1.
- Result latency: last product accepted at edge N → out_valid_o=1 from edge N+2 (one ROUND cycle in between).
- Minimum back-to-back timing: out handshake at edge M → IDLE from M+1 → start_i can be accepted at edge M+1.
- Throughput in ACCUM: one product per cycle. prod_valid_i may drop low for any number of cycles without affecting acc.
- start_i high in the same cycle as prod_valid_i while in IDLE: only the start is taken; the product is not accepted.
- cnt_o wraps from 65535 to 0 with no other effect.

## Test plan
- Defaults, bias_i=0, products 100, 200, -50 (last on -50), out_ready_i=1 → acc=250, out_o=1 ((250+128)>>8), ovf_o=0, cnt_o=3, out_valid_o high exactly at edge N+2.
- bias_i=-1000, product 200 with last → r=(-800+128)>>>8=-3 → out_o=0 (ReLU). Then bias_i=70000, product 0 with last → r=273 → out_o=255 (clamp).
- ACC_W=20, bias_i=0, 17 products of 32767 (last on the 17th) → acc saturates at 524287 and ovf_o=1 from the first saturating accept. Next start clears ovf_o to 0.
- Backpressure: result ready with out_ready_i=0 for 3 cycles → out_valid_o=1 and out_o unchanged for all 3 cycles. prod_ready_o=0 and start_i ignored throughout. Handshake on the 4th cycle → busy_o=0 on the following cycle.
- Bubbles and ignored starts: prod_valid_i toggled 1,0,0,1(last) with products 5,x,x,7 → only 5 and 7 summed (acc=12). A start_i pulse during ACCUM changes nothing.
- Reset mid-ACCUM after 2 products → next cycle all outputs at reset values. A fresh dot product afterward gives a correct result with no residue from the aborted one.
